// File: rtl/sumador_restador_display_mux.sv
// Registered WIDTH-bit adder/subtractor with a scanned common-anode hex display.
// Operands are captured on Cargar; the result and flags land one cycle later with a Valido pulse.
module sumador_restador_display_mux #(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       X,
  input  logic [WIDTH-1:0]       Y,
  input  logic                   Modo,
  input  logic                   Cargar,
  input  logic                   Borrar,
  output logic [WIDTH-1:0]       Resultado,
  output logic                   Acarreo,
  output logic                   Negativo,
  output logic                   Valido,
  output logic [WIDTH/4-1:0]     Anodos,
  output logic [6:0]             Segmentos
);

  localparam int DIGITS = WIDTH / 4;
  localparam int PW     = $clog2(REFRESH_DIV + 1);
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    MOSTRAR = 2'd2
  } estado_t;

  estado_t estado, estado_sig;

  logic [WIDTH-1:0] op_x, op_y, mag;
  logic             op_modo;
  logic             visible;
  logic             captura, commit;
  logic [WIDTH:0]   suma, resta;
  logic [WIDTH-1:0] inversa;
  logic [PW-1:0]    presc;
  logic [IW-1:0]    idx;
  logic [3:0]       nibble;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next-state logic; Borrar wins over Cargar in every state
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (Borrar) estado_sig = REPOSO;
               else if (Cargar) estado_sig = CALCULO;
      CALCULO: estado_sig = Borrar ? REPOSO : MOSTRAR;
      MOSTRAR: if (Borrar) estado_sig = REPOSO;
               else if (Cargar) estado_sig = CALCULO;
      default: estado_sig = REPOSO;
    endcase
  end

  // State-derived controls
  always_comb begin
    captura = 1'b0;
    commit  = 1'b0;
    case (estado)
      REPOSO, MOSTRAR: captura = Cargar & ~Borrar;
      CALCULO:         commit  = ~Borrar;
      default: begin
        captura = 1'b0;
        commit  = 1'b0;
      end
    endcase
  end

  // Both paths are zero-extended, so bit WIDTH is carry-out for add and borrow (X<Y) for sub
  assign suma    = {1'b0, op_x} + {1'b0, op_y};
  assign resta   = {1'b0, op_x} - {1'b0, op_y};
  assign inversa = op_y - op_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_x      <= '0;
      op_y      <= '0;
      op_modo   <= 1'b0;
      Resultado <= '0;
      Acarreo   <= 1'b0;
      Negativo  <= 1'b0;
      Valido    <= 1'b0;
      mag       <= '0;
      visible   <= 1'b0;
    end else begin
      Valido <= 1'b0;
      if (Borrar) begin
        // An abandoned calculation leaves the last committed result untouched
        if (estado != CALCULO) begin
          Resultado <= '0;
          Acarreo   <= 1'b0;
          Negativo  <= 1'b0;
        end
        mag     <= '0;
        visible <= 1'b0;
      end else if (captura) begin
        op_x    <= X;
        op_y    <= Y;
        op_modo <= Modo;
      end else if (commit) begin
        Valido  <= 1'b1;
        visible <= 1'b1;
        if (op_modo) begin
          Resultado <= resta[WIDTH-1:0];
          Acarreo   <= 1'b0;
          Negativo  <= resta[WIDTH];
          mag       <= resta[WIDTH] ? inversa : resta[WIDTH-1:0];
        end else begin
          Resultado <= suma[WIDTH-1:0];
          Acarreo   <= suma[WIDTH];
          Negativo  <= 1'b0;
          mag       <= suma[WIDTH-1:0];
        end
      end
    end
  end

  // Free-running digit scan, independent of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) nibble = mag[4*i +: 4];
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Blank until a result has been committed; Borrar blanks on the same edge it takes effect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Anodos    <= '1;
      Segmentos <= 7'h7F;
    end else if (Borrar || !visible) begin
      Anodos    <= '1;
      Segmentos <= 7'h7F;
    end else begin
      Anodos    <= ~(DIGITS'(1) << idx);
      Segmentos <= hex7(nibble);
    end
  end

endmodule

// File: tb/tb_sumador_restador_display_mux.sv
// Randomised scoreboard bench for sumador_restador_display_mux (WIDTH=8, REFRESH_DIV=4).
// Results are predicted with plain integer arithmetic; the display is predicted from the cycle count.
module tb_sumador_restador_display_mux;
  localparam int W   = 8;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] x, y;
  logic         modo, cargar, borrar;
  logic [W-1:0] resultado;
  logic         acarreo, negativo, valido;
  logic [1:0]   anodos;
  logic [6:0]   segmentos;

  sumador_restador_display_mux #(.WIDTH(W), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .X(x), .Y(y), .Modo(modo), .Cargar(cargar), .Borrar(borrar),
    .Resultado(resultado), .Acarreo(acarreo), .Negativo(negativo), .Valido(valido),
    .Anodos(anodos), .Segmentos(segmentos)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int pend_m;
  logic [W+1:0] exp_q[$];
  logic [6:0]   hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [W-1:0] model_m;
  logic         model_vis;

  // Edges since reset release; the scan phase follows from this alone
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int a, input int b, input logic m);
    int r;
    logic c, n;
    if (!m) begin
      r = a + b;
      c = (r > 255);
      n = 1'b0;
      r = r % 256;
      pend_m = r;
    end else begin
      n = (a < b);
      c = 1'b0;
      r = (a - b + 256) % 256;
      pend_m = n ? (b - a) : r;
    end
    exp_q.push_back({r[7:0], c, n});
  endtask

  // Monitor: every Valido pops one prediction
  always @(negedge clk) begin
    if (rst_n && valido) begin
      if (exp_q.size() == 0) check("spurious_valido", 32'(valido), 32'd0);
      else check("result_flags", 32'({resultado, acarreo, negativo}), 32'(exp_q.pop_front()));
    end
  end

  task automatic check_disp;
    int d;
    logic [1:0] ea;
    logic [6:0] es;
    logic [7:0] sh;
    d = (cyc == 0) ? 0 : ((cyc - 1) / DIV) % 2;
    sh = model_m >> (4 * d);
    ea = model_vis ? ((d == 1) ? 2'b01 : 2'b10) : 2'b11;
    es = model_vis ? hex_tab[sh[3:0]] : 7'h7F;
    check("anodos", 32'(anodos), 32'(ea));
    check("segmentos", 32'(segmentos), 32'(es));
  endtask

  task automatic disp_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check_disp();
    end
  endtask

  task automatic do_load(input int a, input int b, input logic m);
    @(negedge clk);
    x = W'(a); y = W'(b); modo = m; cargar = 1'b1;
    push_exp(a, b, m);
    @(negedge clk);
    cargar = 1'b0;
    @(negedge clk);
    model_m = W'(pend_m);
    model_vis = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  int da [8] = '{'h3C, 'h15, 'hF0, 'hFF, 'hFF, 'h00, 'h5A, 'h00};
  int db [8] = '{'h15, 'h3C, 'h20, 'hFF, 'h01, 'hFF, 'h5A, 'h00};
  logic dm [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; x = '0; y = '0; modo = 1'b0; cargar = 1'b0; borrar = 1'b0;
    model_m = '0; model_vis = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_resultado", 32'(resultado), 32'd0);
    check("rst_acarreo", 32'(acarreo), 32'd0);
    check("rst_negativo", 32'(negativo), 32'd0);
    check("rst_valido", 32'(valido), 32'd0);
    check("rst_anodos", 32'(anodos), 32'h3);
    check("rst_segmentos", 32'(segmentos), 32'h7F);
    rst_n = 1'b1;
    disp_cycles(3);

    // Directed cases incl. carry, wrap-to-zero, borrow and equal operands
    for (int i = 0; i < 8; i++) begin
      do_load(da[i], db[i], dm[i]);
      disp_cycles(10);
    end

    // Cargar and Borrar together from MOSTRAR
    do_load('h3C, 'h15, 1'b1);
    @(negedge clk);
    cargar = 1'b1; borrar = 1'b1;
    @(negedge clk);
    cargar = 1'b0; borrar = 1'b0;
    model_vis = 1'b0; model_m = '0;
    check("clr_resultado", 32'(resultado), 32'd0);
    check("clr_acarreo", 32'(acarreo), 32'd0);
    check("clr_negativo", 32'(negativo), 32'd0);
    check("clr_valido", 32'(valido), 32'd0);
    check("clr_anodos", 32'(anodos), 32'h3);
    check("clr_segmentos", 32'(segmentos), 32'h7F);
    disp_cycles(4);

    // Cargar held through CALCULO from REPOSO: one Valido only
    @(negedge clk);
    x = 8'h9C; y = 8'h47; modo = 1'b0; cargar = 1'b1;
    push_exp('h9C, 'h47, 1'b0);
    @(negedge clk);
    check("calc_blank_anodos", 32'(anodos), 32'h3);
    @(negedge clk);
    cargar = 1'b0;
    model_m = W'(pend_m); model_vis = 1'b1;
    disp_cycles(6);

    // Cargar held in MOSTRAR: reload every other cycle, two Valido in four cycles
    @(negedge clk);
    x = 8'hA7; y = 8'hC3; modo = 1'b1; cargar = 1'b1;
    push_exp('hA7, 'hC3, 1'b1);
    push_exp('hA7, 'hC3, 1'b1);
    repeat (4) @(negedge clk);
    cargar = 1'b0;
    model_m = W'(pend_m);
    disp_cycles(6);

    for (int i = 0; i < 16; i++) begin
      do_load($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      disp_cycles($urandom_range(1, 6));
    end

    // Reset asserted while in CALCULO, between clock edges
    do_load('hEE, 'h11, 1'b0);
    @(negedge clk);
    x = 8'h12; y = 8'h34; modo = 1'b0; cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_resultado", 32'(resultado), 32'd0);
    check("async_valido", 32'(valido), 32'd0);
    check("async_anodos", 32'(anodos), 32'h3);
    check("async_segmentos", 32'(segmentos), 32'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_vis = 1'b0; model_m = '0;
    disp_cycles(6);
    check("post_rst_resultado", 32'(resultado), 32'd0);

    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
